// File: rtl/sqrt2_pkg.sv
// rtl/sqrt2_pkg.sv - shared widths, constants and FSM states for the binary16 square root
package sqrt2_pkg;
  localparam int WORD_W   = 16;
  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;
  localparam int EXP_BIAS = 15;
  localparam int ROOT_W   = 11;
  localparam int RAD_W    = 22;

  localparam logic [WORD_W-1:0] QNAN = 16'hFE00;
  localparam logic [WORD_W-1:0] PINF = 16'h7C00;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/sqrt2_isqrt.sv
// rtl/sqrt2_isqrt.sv - restoring integer square root, one root bit per cycle, MSB first
module sqrt2_isqrt
  import sqrt2_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start,
  input  logic [RAD_W-1:0]  radicand,
  output logic              done,
  output logic [ROOT_W-1:0] root
);
  logic              running;
  logic [3:0]        count;
  logic [13:0]       rem;
  logic [RAD_W-1:0]  rad;

  logic              load;
  logic [13:0]       src_rem;
  logic [ROOT_W-1:0] src_root;
  logic [RAD_W-1:0]  src_rad;
  logic [13:0]       shifted;
  logic [13:0]       trial;
  logic [13:0]       rem_d;
  logic [ROOT_W-1:0] root_d;

  // The loading cycle already performs the first iteration on the fresh radicand.
  always_comb begin
    load     = start && !running && !done;
    src_rem  = load ? '0 : rem;
    src_root = load ? '0 : root;
    src_rad  = load ? radicand : rad;
    shifted  = (src_rem << 2) | {12'd0, src_rad[RAD_W-1 -: 2]};
    trial    = {1'b0, src_root, 2'b01};
    if (shifted >= trial) begin
      rem_d  = shifted - trial;
      root_d = {src_root[ROOT_W-2:0], 1'b1};
    end else begin
      rem_d  = shifted;
      root_d = {src_root[ROOT_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      running <= 1'b0;
      done    <= 1'b0;
      count   <= '0;
      rem     <= '0;
      root    <= '0;
      rad     <= '0;
    end else if (load || running) begin
      rem  <= rem_d;
      root <= root_d;
      rad  <= src_rad << 2;
      if (load) begin
        running <= 1'b1;
        count   <= 4'd10;
      end else begin
        count <= count - 4'd1;
        if (count == 4'd1) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/sqrt2.sv
// rtl/sqrt2.sv - sequential binary16 square root (truncating) on a shared bidirectional bus
module sqrt2
  import sqrt2_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  inout  wire  [WORD_W-1:0] IO_DATA,
  output logic              IS_NAN,
  output logic              IS_PINF,
  output logic              IS_NINF,
  output logic              RESULT
);
  state_t              state, next_state;
  logic [WORD_W-1:0]   operand, result_q, result_d;
  logic                nan_q, pinf_q, nan_d, pinf_d, load_result;

  logic [EXP_W-1:0]    exp_f;
  logic [FRAC_W-1:0]   frac;
  logic                special, special_nan, special_pinf;
  logic [WORD_W-1:0]   special_val;
  logic [3:0]          msb, shift;
  logic [ROOT_W-1:0]   mant;
  logic signed [6:0]   e_unb, e_even;
  logic [RAD_W-1:0]    radicand;
  logic [EXP_W-1:0]    res_exp;
  logic [WORD_W-1:0]   packed_val;

  logic                core_start, core_done;
  logic [ROOT_W-1:0]   root;

  assign exp_f = operand[14:10];
  assign frac  = operand[9:0];

  always_comb begin
    special      = 1'b1;
    special_nan  = 1'b0;
    special_pinf = 1'b0;
    special_val  = operand;
    if (exp_f == '1 && frac != '0) begin
      special_val = operand | 16'h0200;
      special_nan = 1'b1;
    end else if (operand[15] && operand[14:0] != '0) begin
      special_val = QNAN;
      special_nan = 1'b1;
    end else if (exp_f == '1) begin
      special_val  = PINF;
      special_pinf = 1'b1;
    end else if (operand[14:0] != '0) begin
      special = 1'b0;
    end
  end

  always_comb begin
    msb = '0;
    for (int i = 0; i < FRAC_W; i++) begin
      if (frac[i]) msb = 4'(i);
    end
    shift = 4'd10 - msb;
    if (exp_f == '0) begin
      mant  = {1'b0, frac} << shift;
      e_unb = -7'sd14 - $signed({3'b000, shift});
    end else begin
      mant  = {1'b1, frac};
      e_unb = $signed({2'b00, exp_f}) - 7'sd15;
    end
    if (e_unb[0]) begin
      radicand = {mant, 11'b0};
      e_even   = e_unb - 7'sd1;
    end else begin
      radicand = {1'b0, mant, 10'b0};
      e_even   = e_unb;
    end
    // root[10] is always 1 and carries into the exponent field, so bias it by one less.
    res_exp    = 5'((e_even >>> 1) + 7'(EXP_BIAS - 1));
    packed_val = {1'b0, res_exp, 10'b0} + {5'b0, root};
  end

  sqrt2_isqrt u_isqrt (
    .clk      (CLK),
    .reset    (RESET),
    .clear    (state != CALC),
    .start    (core_start),
    .radicand (radicand),
    .done     (core_done),
    .root     (root)
  );

  always_comb begin
    next_state  = state;
    load_result = 1'b0;
    core_start  = 1'b0;
    result_d    = special ? special_val : packed_val;
    nan_d       = special_nan;
    pinf_d      = special_pinf;
    case (state)
      IDLE: if (ENABLE) next_state = CALC;
      CALC: begin
        if (!ENABLE) begin
          next_state = IDLE;
        end else if (special) begin
          next_state  = DONE;
          load_result = 1'b1;
        end else begin
          core_start = 1'b1;
          if (core_done) begin
            next_state  = DONE;
            load_result = 1'b1;
          end
        end
      end
      DONE: if (!ENABLE) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      operand  <= '0;
      result_q <= '0;
      nan_q    <= 1'b0;
      pinf_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE) operand <= IO_DATA;
      if (load_result) begin
        result_q <= result_d;
        nan_q    <= nan_d;
        pinf_q   <= pinf_d;
      end
    end
  end

  assign RESULT  = (state == DONE);
  assign IS_NAN  = RESULT && nan_q;
  assign IS_PINF = RESULT && pinf_q;
  assign IS_NINF = 1'b0;
  assign IO_DATA = RESULT ? result_q : 16'bz;
endmodule

// File: tb/tb_sqrt2.sv
// tb/tb_sqrt2.sv - randomized self-checking bench for sqrt2 against an exact-arithmetic model
module tb_sqrt2;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        host_drive = 1'b1;
  logic [15:0] host_data = 16'h0000;
  wire  [15:0] io_data;
  logic        is_nan, is_pinf, is_ninf, result;

  int errors = 0;
  int checks = 0;

  assign io_data = host_drive ? host_data : 16'bz;

  always #5 clk = ~clk;

  sqrt2 dut (
    .CLK     (clk),
    .RESET   (reset),
    .ENABLE  (enable),
    .IO_DATA (io_data),
    .IS_NAN  (is_nan),
    .IS_PINF (is_pinf),
    .IS_NINF (is_ninf),
    .RESULT  (result)
  );

  // Value of a finite non-negative binary16 in units of 2^-24.
  function automatic logic [127:0] units(input logic [15:0] h);
    if (h[14:10] == 5'd0) return 128'(h[9:0]);
    return 128'({1'b1, h[9:0]}) << (h[14:10] - 5'd1);
  endfunction

  // {nan, pinf, value}: largest binary16 r with r*r <= x for positive finite x.
  function automatic logic [17:0] ref_sqrt(input logic [15:0] x);
    logic [127:0] target, u;
    int lo, hi, mid;
    if (x[14:10] == 5'h1F && x[9:0] != 0) return {2'b10, x | 16'h0200};
    if (x[15] && x[14:0] != 0) return {2'b10, 16'hFE00};
    if (x == 16'h7C00) return {2'b01, 16'h7C00};
    if (x[14:0] == 0) return {2'b00, x};
    target = units(x) << 24;
    lo = 0;
    hi = 16'h7BFF;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      u = units(16'(mid));
      if (u * u <= target) lo = mid;
      else hi = mid - 1;
    end
    return {2'b00, 16'(lo)};
  endfunction

  function automatic bit is_special(input logic [15:0] x);
    return (x[14:10] == 5'h1F) || x[15] || (x[14:0] == 0);
  endfunction

  task automatic run_op(input logic [15:0] op, input int hold, output int edges,
                        output logic [15:0] data, output logic [2:0] flags,
                        output logic edge1_result, output logic held,
                        output logic [3:0] after_drop);
    @(negedge clk);
    host_drive = 1'b1;
    host_data  = op;
    enable     = 1'b1;
    @(posedge clk); #1;
    edge1_result = result;
    host_drive   = 1'b0;
    edges = 1;
    while (result !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    data  = io_data;
    flags = {is_nan, is_pinf, is_ninf};
    held  = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (result !== 1'b1 || io_data !== data || {is_nan, is_pinf, is_ninf} !== flags) held = 1'b0;
    end
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk); #1;
    after_drop = {result, is_nan, is_pinf, is_ninf};
    @(negedge clk);
    host_drive = 1'b1;
    host_data  = 16'($urandom);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({result, is_nan, is_pinf, is_ninf} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000", {result, is_nan, is_pinf, is_ninf});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_vectors;
    logic [15:0] ops [22] = '{16'h4800, 16'h4000, 16'h4200, 16'h4500, 16'h4700, 16'h3400,
                              16'h3C00, 16'h3E00, 16'h3555, 16'h7BFF, 16'h03FF, 16'h0001,
                              16'h0010, 16'h0000, 16'h8000, 16'h7C00, 16'h7E00, 16'hFE00,
                              16'hBC00, 16'hC000, 16'hB800, 16'hFC00};
    logic [15:0] exps [22] = '{16'h41A8, 16'h3DA8, 16'h3EED, 16'h4078, 16'h414A, 16'h3800,
                               16'h3C00, 16'h3CE6, 16'h389E, 16'h5BFF, 16'h1FFE, 16'h0C00,
                               16'h1400, 16'h0000, 16'h8000, 16'h7C00, 16'h7E00, 16'hFE00,
                               16'hFE00, 16'hFE00, 16'hFE00, 16'hFE00};
    logic [2:0] eflags [22] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                3'b000, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    int edges, want_edges;
    logic [15:0] data;
    logic [2:0] flags;
    logic e1, held;
    logic [3:0] after;
    for (int i = 0; i < 22; i++) begin
      want_edges = is_special(ops[i]) ? 2 : 13;
      run_op(ops[i], 2, edges, data, flags, e1, held, after);
      checks++;
      if (edges != want_edges) begin
        errors++;
        $display("FAIL vec_latency op=%h: got %0d expected %0d", ops[i], edges, want_edges);
      end
      checks++;
      if (data !== exps[i]) begin
        errors++;
        $display("FAIL vec_data op=%h: got %h expected %h", ops[i], data, exps[i]);
      end
      checks++;
      if (flags !== eflags[i]) begin
        errors++;
        $display("FAIL vec_flags op=%h: got %b expected %b", ops[i], flags, eflags[i]);
      end
      checks++;
      if (e1 !== 1'b0) begin
        errors++;
        $display("FAIL vec_edge1_drive op=%h: got %b expected 0", ops[i], e1);
      end
      checks++;
      if (held !== 1'b1) begin
        errors++;
        $display("FAIL vec_hold op=%h: got %b expected 1", ops[i], held);
      end
      checks++;
      if (after !== 4'b0000) begin
        errors++;
        $display("FAIL vec_release op=%h: got %b expected 0000", ops[i], after);
      end
    end
  endtask

  task automatic test_random_back_to_back;
    int edges, want_edges;
    logic [15:0] op, data;
    logic [17:0] want;
    logic [2:0] flags;
    logic e1, held;
    logic [3:0] after;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0:       op = {6'b000000, 10'($urandom)};
        1:       op = {1'b1, 15'($urandom)};
        2:       op = {6'b011111, 10'($urandom)};
        default: op = {1'b0, 5'($urandom_range(1, 30)), 10'($urandom)};
      endcase
      want = ref_sqrt(op);
      want_edges = is_special(op) ? 2 : 13;
      run_op(op, $urandom_range(0, 3), edges, data, flags, e1, held, after);
      checks++;
      if (edges != want_edges || e1 !== 1'b0) begin
        errors++;
        $display("FAIL rnd_latency op=%h: got %0d edge1=%b expected %0d edge1=0", op, edges, e1, want_edges);
      end
      checks++;
      if (data !== want[15:0] || flags !== {want[17:16], 1'b0}) begin
        errors++;
        $display("FAIL rnd_result op=%h: got %h/%b expected %h/%b", op, data, flags, want[15:0], {want[17:16], 1'b0});
      end
      checks++;
      if (held !== 1'b1 || after !== 4'b0000) begin
        errors++;
        $display("FAIL rnd_hold_release op=%h: got held=%b after=%b expected 1/0000", op, held, after);
      end
    end
  endtask

  task automatic test_abort;
    int edges;
    logic [15:0] data;
    logic [2:0] flags;
    logic e1, held, seen;
    logic [3:0] after;
    @(negedge clk);
    host_drive = 1'b1;
    host_data  = 16'h4800;
    enable     = 1'b1;
    @(posedge clk); #1;
    host_drive = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (result !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_result: got %b expected 0", seen);
    end
    @(negedge clk);
    host_drive = 1'b1;
    run_op(16'h4200, 1, edges, data, flags, e1, held, after);
    checks++;
    if (edges != 13 || data !== 16'h3EED) begin
      errors++;
      $display("FAIL abort_recover: got %0d/%h expected 13/3eed", edges, data);
    end
  endtask

  task automatic test_reset_mid_calc;
    int edges;
    logic [15:0] data;
    logic [2:0] flags;
    logic e1, held;
    logic [3:0] after;
    @(negedge clk);
    host_drive = 1'b1;
    host_data  = 16'h4700;
    enable     = 1'b1;
    @(posedge clk); #1;
    host_drive = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({result, is_nan, is_pinf, is_ninf} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_calc: got %b expected 0000", {result, is_nan, is_pinf, is_ninf});
    end
    @(negedge clk);
    enable = 1'b0;
    host_drive = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_op(16'h3E00, 1, edges, data, flags, e1, held, after);
    checks++;
    if (edges != 13 || data !== 16'h3CE6 || flags !== 3'b000) begin
      errors++;
      $display("FAIL reset_recover: got %0d/%h/%b expected 13/3ce6/000", edges, data, flags);
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_random_back_to_back;
    test_abort;
    test_reset_mid_calc;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end
endmodule
